// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares the single cache port between instruction fetch
// (IF) and data access (MEM). Data accesses win arbitration, but a saturating
// streak counter forces an IF grant after MAX_DATA_STREAK consecutive MEM
// grants made while IF was waiting. One transaction is in flight at a time,
// and there is always one IDLE cycle between transactions.
module fetch_mem_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   output logic              mem_done,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              cache_req,
   output logic              cache_we,
   output logic [ADDR_W-1:0] cache_addr,
   output logic [DATA_W-1:0] cache_wdata,
   input  logic              cache_done,
   input  logic [DATA_W-1:0] cache_rdata
);

   localparam int                  STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IF  = 2'd1,
      BUSY_MEM = 2'd2
   } state_t;

   state_t              state;
   logic [STREAK_W-1:0] streak;
   logic                force_if;
   logic                grant_mem;

   // IF has waited through a full streak of MEM grants: it must win this time
   assign force_if  = if_req && (streak == STREAK_MAX);
   assign grant_mem = mem_req && !force_if;

   // Stalls hold the pipeline registers until the done pulse releases them
   assign stall_if  = if_req  & ~if_done;
   assign stall_mem = mem_req & ~mem_done;

   // Arbitration FSM: grant, hold the cache request, retire on cache_done
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         streak      <= '0;
         cache_req   <= 1'b0;
         cache_we    <= 1'b0;
         cache_addr  <= '0;
         cache_wdata <= '0;
         if_done     <= 1'b0;
         mem_done    <= 1'b0;
         if_rdata    <= '0;
         mem_rdata   <= '0;
      end else begin
         if_done  <= 1'b0;
         mem_done <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_mem) begin
                  state       <= BUSY_MEM;
                  cache_req   <= 1'b1;
                  cache_we    <= mem_we;
                  cache_addr  <= mem_addr;
                  cache_wdata <= mem_wdata;
                  // Count only grants that made a waiting fetch lose
                  if (!if_req)
                     streak <= '0;
                  else if (streak != STREAK_MAX)
                     streak <= streak + 1'b1;
               end else if (if_req) begin
                  state      <= BUSY_IF;
                  cache_req  <= 1'b1;
                  cache_we   <= 1'b0;
                  cache_addr <= if_addr;
                  streak     <= '0;
               end
            end
            BUSY_IF: begin
               if (cache_done) begin
                  state     <= IDLE;
                  cache_req <= 1'b0;
                  if_done   <= 1'b1;
                  if_rdata  <= cache_rdata;
               end
            end
            BUSY_MEM: begin
               if (cache_done) begin
                  state     <= IDLE;
                  cache_req <= 1'b0;
                  mem_done  <= 1'b1;
                  // Stores leave the last load result untouched
                  if (!cache_we)
                     mem_rdata <= cache_rdata;
               end
            end
            default: begin
               state     <= IDLE;
               cache_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Scoreboard bench for fetch_mem_arbiter: stimulus pushes expected grants and
// done data into queues; a monitor pops and compares whenever the DUT presents
// a grant or a done pulse. A small cache responder answers each request after
// a programmable latency.
module tb_fetch_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, mem_req, mem_we;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic        if_done, mem_done, stall_if, stall_mem;
   logic [31:0] if_rdata, mem_rdata;
   logic        cache_req, cache_we, cache_done;
   logic [31:0] cache_addr, cache_wdata, cache_rdata;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } grant_t;

   grant_t      grant_q[$];
   logic [31:0] if_q[$];
   logic [31:0] mem_q[$];

   int   n_cmp = 0;
   int   n_err = 0;
   int   cache_lat = 1;
   int   idle_req_cnt = 0;
   int   idle_done_cnt = 0;
   logic chk_zero = 1'b0;
   logic chk_quiet = 1'b0;
   logic stim_done = 1'b0;

   fetch_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .if_done(if_done), .if_rdata(if_rdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .cache_req(cache_req), .cache_we(cache_we), .cache_addr(cache_addr),
      .cache_wdata(cache_wdata), .cache_done(cache_done), .cache_rdata(cache_rdata)
   );

   always #5 clk = ~clk;

   // Cache contents: one hand-picked word, the rest a fixed pattern of the address
   function automatic logic [31:0] cache_model(input logic [31:0] a);
      return (a == 32'h0000_0040) ? 32'h2008_0005 : (a ^ 32'hC0DE_0000);
   endfunction

   // Cache responder: answers each request after cache_lat cycles
   initial begin
      int          lat;
      logic [31:0] a;
      cache_done  = 1'b0;
      cache_rdata = 32'hFFFF_FFFF;
      forever begin
         @(negedge clk);
         if (cache_req) begin
            lat = cache_lat;
            a   = cache_addr;
            repeat (lat - 1) @(negedge clk);
            #1;
            cache_done  = 1'b1;
            cache_rdata = cache_model(a);
            @(negedge clk);
            #1;
            cache_done  = 1'b0;
            cache_rdata = 32'hFFFF_FFFF;
         end else if (idle_req_cnt != idle_done_cnt) begin
            #1;
            cache_done  = 1'b1;
            cache_rdata = 32'hBAD0_BAD0;
            @(negedge clk);
            #1;
            cache_done  = 1'b0;
            cache_rdata = 32'hFFFF_FFFF;
            idle_done_cnt++;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      logic   prev_req;
      grant_t cur;
      prev_req = 1'b0;
      cur      = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
      while (!stim_done) begin
         @(negedge clk);
         if (chk_zero) begin
            check("zero_cache_req",   32'(cache_req),   32'h0);
            check("zero_cache_we",    32'(cache_we),    32'h0);
            check("zero_cache_addr",  cache_addr,       32'h0);
            check("zero_cache_wdata", cache_wdata,      32'h0);
            check("zero_if_rdata",    if_rdata,         32'h0);
            check("zero_mem_rdata",   mem_rdata,        32'h0);
            check("zero_stall_if",    32'(stall_if),    32'h0);
            check("zero_stall_mem",   32'(stall_mem),   32'h0);
         end
         if (chk_quiet)
            check("quiet_cache_req", 32'(cache_req), 32'h0);
         if (cache_req && !prev_req) begin
            if (grant_q.size() == 0) begin
               check("unexpected_grant_addr", cache_addr, 32'hxxxx_xxxx);
            end else begin
               cur = grant_q.pop_front();
               check("grant_addr",  cache_addr,      cur.addr);
               check("grant_we",    32'(cache_we),   32'(cur.we));
               check("grant_wdata", cache_wdata,     cur.wdata);
            end
         end else if (cache_req && prev_req) begin
            check("hold_addr",  cache_addr,    cur.addr);
            check("hold_we",    32'(cache_we), 32'(cur.we));
            check("hold_wdata", cache_wdata,   cur.wdata);
         end
         prev_req = cache_req;
         if (if_done) begin
            if (if_q.size() == 0)
               check("unexpected_if_done", 32'(if_done), 32'h0);
            else
               check("if_rdata", if_rdata, if_q.pop_front());
            check("stall_if_done", 32'(stall_if), 32'h0);
         end else begin
            check("stall_if", 32'(stall_if), 32'(if_req));
         end
         if (mem_done) begin
            if (mem_q.size() == 0)
               check("unexpected_mem_done", 32'(mem_done), 32'h0);
            else
               check("mem_rdata", mem_rdata, mem_q.pop_front());
            check("stall_mem_done", 32'(stall_mem), 32'h0);
         end else begin
            check("stall_mem", 32'(stall_mem), 32'(mem_req));
         end
      end
      check("grants_left", 32'(grant_q.size()), 32'h0);
      check("if_left",     32'(if_q.size()),    32'h0);
      check("mem_left",    32'(mem_q.size()),   32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to the drive point of the next cycle
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_grant(input logic we, input logic [31:0] a, input logic [31:0] wd);
      grant_t g;
      g.we = we; g.addr = a; g.wdata = wd;
      grant_q.push_back(g);
   endtask

   // Wait (bounded) for a done pulse; returns at the drive point of the done cycle
   task automatic wait_done(input logic is_if);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            $display("FAIL wait_done timeout: no %s done after %0d cycles", is_if ? "if" : "mem", n);
            $fatal(1);
         end
      end while (is_if ? !if_done : !mem_done);
      #1;
   endtask

   // Stimulus
   initial begin
      int n, ic, mc;
      rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
      chk_zero = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();
      chk_zero = 1'b0;

      // Single fetch, 3-cycle cache
      cache_lat = 3;
      push_grant(1'b0, 32'h0000_0040, 32'h0);
      if_q.push_back(32'h2008_0005);
      if_addr = 32'h0000_0040; if_req = 1'b1;
      wait_done(1'b1);
      if_req = 1'b0;
      repeat (2) tick();

      // Store and fetch together: MEM first, then IF; store leaves mem_rdata at 0
      cache_lat = 1;
      push_grant(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
      push_grant(1'b0, 32'h0000_0044, 32'hDEAD_BEEF);
      mem_q.push_back(32'h0);
      if_q.push_back(32'hC0DE_0044);
      mem_we = 1'b1; mem_addr = 32'h0000_0100; mem_wdata = 32'hDEAD_BEEF; mem_req = 1'b1;
      if_addr = 32'h0000_0044; if_req = 1'b1;
      wait_done(1'b0);
      mem_req = 1'b0;
      wait_done(1'b1);
      if_req = 1'b0;
      repeat (2) tick();

      // cache_done while idle is ignored
      chk_quiet = 1'b1;
      idle_req_cnt++;
      repeat (4) tick();
      chk_quiet = 1'b0;

      // Both held, 1-cycle cache: M M M M I M M M M I, then M alone
      for (int i = 0; i < 11; i++) begin
         if (i == 4 || i == 9) push_grant(1'b0, 32'h0000_0080, 32'h1111_2222);
         else                  push_grant(1'b0, 32'h0000_0200, 32'h1111_2222);
      end
      for (int i = 0; i < 9; i++) mem_q.push_back(32'hC0DE_0200);
      for (int i = 0; i < 2; i++) if_q.push_back(32'hC0DE_0080);
      mem_we = 1'b0; mem_addr = 32'h0000_0200; mem_wdata = 32'h1111_2222; mem_req = 1'b1;
      if_addr = 32'h0000_0080; if_req = 1'b1;
      ic = 0; mc = 0; n = 0;
      while ((ic < 2 || mc < 9) && n < 300) begin
         @(negedge clk);
         n++;
         if (if_done)  ic++;
         if (mem_done) mc++;
         #1;
         if (ic >= 2) if_req = 1'b0;
         if (mc >= 9) mem_req = 1'b0;
      end
      if_req = 1'b0; mem_req = 1'b0;
      repeat (3) tick();

      // Build a streak of 4, then reset during the 4th (slow) MEM access
      for (int i = 0; i < 4; i++) push_grant(1'b0, 32'h0000_0300, 32'h3333_4444);
      for (int i = 0; i < 3; i++) mem_q.push_back(32'hC0DE_0300);
      mem_addr = 32'h0000_0300; mem_wdata = 32'h3333_4444; mem_req = 1'b1;
      if_addr = 32'h0000_0090; if_req = 1'b1;
      mc = 0; n = 0;
      while (mc < 3 && n < 100) begin
         @(negedge clk);
         n++;
         if (mem_done) mc++;
         #1;
         if (mc >= 3) cache_lat = 6;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cache_req && n < 20);
      #1;
      tick();
      rst = 1'b1; chk_zero = 1'b1; if_req = 1'b0; mem_req = 1'b0;
      tick();
      rst = 1'b0;
      repeat (2) tick();
      chk_zero = 1'b0;
      repeat (10) tick();

      // Streak cleared by reset: 4 MEM grants precede the forced IF grant
      cache_lat = 1;
      for (int i = 0; i < 4; i++) push_grant(1'b0, 32'h0000_0300, 32'h3333_4444);
      push_grant(1'b0, 32'h0000_0090, 32'h3333_4444);
      for (int i = 0; i < 4; i++) mem_q.push_back(32'hC0DE_0300);
      if_q.push_back(32'hC0DE_0090);
      mem_req = 1'b1; if_req = 1'b1;
      wait_done(1'b1);
      if_req = 1'b0; mem_req = 1'b0;
      repeat (4) tick();

      stim_done = 1'b1;
   end

endmodule
